// File: rtl/mult_req_sched_pkg.sv
// Shared widths for the field-multiplier requester slice.
package mult_req_sched_pkg;

  localparam int unsigned FE_W   = 255;
  localparam int unsigned OPND_W = 256;
  localparam int unsigned PROD_W = 512;

endpackage

// File: rtl/mult_rsp_fifo.sv
// Synchronous response FIFO; a push while full is only honoured alongside a pop.
module mult_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mult_req_sched.sv
// Requester-side scheduler for the free-running field multiplier: credit-gated
// issue, tag pipeline matched to multiplier latency, in-order response FIFO.
module mult_req_sched
  import mult_req_sched_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 8,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned RES_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPND_W-1:0] req_op0,
  input  logic [OPND_W-1:0] req_op1,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [OPND_W-1:0] mult_in0,
  output logic [OPND_W-1:0] mult_in1,
  input  logic [FE_W-1:0]   mult_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FE_W-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic              ovf_err
);

  localparam int unsigned CRW   = $clog2(RES_DEPTH + 1);
  localparam int unsigned ENT_W = FE_W + TAG_W;

  logic                             accept;
  logic                             pop;
  logic                             capture;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CRW-1:0]                   fifo_count;
  logic [ENT_W-1:0]                 fifo_dout;
  logic [CRW-1:0]                   credit;
  logic [CRW-1:0]                   credit_nxt;
  logic [MULT_LATENCY:0]            pipe_vld;
  logic [MULT_LATENCY:0][TAG_W-1:0] pipe_tag;

  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;
  assign capture   = pipe_vld[MULT_LATENCY];
  assign {rsp_data, rsp_tag} = fifo_dout;

  always_comb begin
    credit_nxt = credit;
    if (accept && !pop) begin
      credit_nxt = credit - CRW'(1);
    end else if (pop && !accept) begin
      credit_nxt = credit + CRW'(1);
    end
  end

  // Operand registers hold their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_in0 <= '0;
      mult_in1 <= '0;
    end else if (accept) begin
      mult_in0 <= req_op0;
      mult_in1 <= req_op1;
    end
  end

  // Tag pipe is one stage longer than the multiplier so its tail lines up with mult_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_tag <= '0;
    end else begin
      pipe_vld <= {pipe_vld[MULT_LATENCY-1:0], accept};
      pipe_tag <= {pipe_tag[MULT_LATENCY-1:0], req_tag};
    end
  end

  // ready/busy are registered from the next credit value so they never look at req_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit    <= CRW'(RES_DEPTH);
      req_ready <= 1'b1;
      busy      <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      credit    <= credit_nxt;
      req_ready <= (credit_nxt != '0);
      busy      <= (credit_nxt != CRW'(RES_DEPTH));
      if (capture && fifo_full && !pop) begin
        ovf_err <= 1'b1;
      end
    end
  end

  mult_rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RES_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   ({mult_out, pipe_tag[MULT_LATENCY]}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  // Every credit is either free, riding the tag pipe, or parked in the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(credit) + 32'($countones(pipe_vld)) + 32'(fifo_count) == RES_DEPTH);
    end
  end

endmodule

// File: tb/tb_mult_req_sched.sv
// Directed bench for mult_req_sched with a modular-multiplier model and an in-order scoreboard.
module tb_mult_req_sched;
  import mult_req_sched_pkg::*;

  localparam int unsigned L  = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned D  = 4;
  localparam logic [PROD_W-1:0] PMOD = (PROD_W'(1) << 255) - PROD_W'(19);

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [OPND_W-1:0] req_op0;
  logic [OPND_W-1:0] req_op1;
  logic [TW-1:0]     req_tag;
  logic [OPND_W-1:0] mult_in0;
  logic [OPND_W-1:0] mult_in1;
  logic [FE_W-1:0]   mult_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [FE_W-1:0]   rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic              busy;
  logic              ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc     = 0;
  logic [FE_W+TW-1:0] sb_q [$];
  logic [FE_W-1:0]    mstage [L];

  mult_req_sched #(.MULT_LATENCY(L), .TAG_W(TW), .RES_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_tag(req_tag),
    .mult_in0(mult_in0), .mult_in1(mult_in1), .mult_out(mult_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [FE_W-1:0] fmul(input logic [OPND_W-1:0] a, input logic [OPND_W-1:0] b);
    logic [PROD_W-1:0] pr;
    pr = PROD_W'(a) * PROD_W'(b);
    return FE_W'(pr % PMOD);
  endfunction

  // Ideal free-running multiplier: L register stages from operand registers to mult_out.
  always @(posedge clk) begin
    mstage[0] <= fmul(mult_in0, mult_in1);
    for (int i = 1; i < int'(L); i++) mstage[i] <= mstage[i-1];
  end
  assign mult_out = mstage[L-1];

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
    end
  endtask

  task automatic chki(input string name, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [259:0] obs, input logic [259:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk1({pfx, "_req_ready"}, req_ready, 1'b1);
    chkw({pfx, "_mult_in0"}, 260'(mult_in0), 260'(0));
    chkw({pfx, "_mult_in1"}, 260'(mult_in1), 260'(0));
    chk1({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
    chkw({pfx, "_rsp_data"}, 260'(rsp_data), 260'(0));
    chkw({pfx, "_rsp_tag"}, 260'(rsp_tag), 260'(0));
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_ovf_err"}, ovf_err, 1'b0);
  endtask

  // Scoreboard: sample mid-cycle, after the driver has settled inputs for the next edge.
  always begin
    logic [FE_W+TW-1:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        sb_q.push_back({fmul(req_op0, req_op1), req_tag});
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        chk1("sb_expected_rsp", 1'(sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chkw("sb_data", 260'(rsp_data), 260'(e[FE_W+TW-1:TW]));
          chkw("sb_tag", 260'(rsp_tag), 260'(e[TW-1:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    int acc0;
    logic seen;
    logic [OPND_W-1:0] m1;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_tag = '0;
    #2;
    chk_reset_vals("rst0");
    tick();
    rst = 1'b0;
    tick();

    // Single op: 3*5 with tag 1, latency check
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_op0 = OPND_W'(3); req_op1 = OPND_W'(5); req_tag = TW'(1);
    chk1("t1_req_ready", req_ready, 1'b1);
    tick();
    acc_cyc = cyc;
    req_valid = 1'b0;
    chk1("t1_busy", busy, 1'b1);
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    chk1("t1_rsp_valid", rsp_valid, 1'b1);
    chki("t1_latency", cyc - acc_cyc, int'(L) + 1);
    chkw("t1_rsp_data", 260'(rsp_data), 260'(15));
    chkw("t1_rsp_tag", 260'(rsp_tag), 260'(1));
    tick();
    chk1("t1_rsp_valid_after_pop", rsp_valid, 1'b0);
    chk1("t1_busy_after_pop", busy, 1'b0);

    // Back-to-back: D requests, tags 0..D-1
    req_valid = 1'b1;
    for (int i = 0; i < int'(D); i++) begin
      req_tag = TW'(i);
      req_op0 = {8{$urandom}};
      req_op1 = {8{$urandom}};
      chk1("t2_req_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    for (int i = 0; i < int'(D); i++) begin
      chk1("t2_rsp_valid", rsp_valid, 1'b1);
      chkw("t2_rsp_tag", 260'(rsp_tag), 260'(i));
      tick();
    end
    chk1("t2_drained", rsp_valid, 1'b0);

    // Backpressure: 6 offered, only D accepted until a pop frees a credit
    rsp_ready = 1'b0;
    acc0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < int'(D); i++) begin
      req_tag = TW'(i);
      req_op0 = {8{$urandom}};
      req_op1 = {8{$urandom}};
      chk1("t3_req_ready", req_ready, 1'b1);
      tick();
    end
    req_tag = TW'(4);
    chk1("t3_not_ready_after_4", req_ready, 1'b0);
    for (int i = 0; i < int'(L) + 4; i++) tick();
    chk1("t3_still_not_ready", req_ready, 1'b0);
    chki("t3_accepted", n_acc - acc0, int'(D));
    chk1("t3_ovf", ovf_err, 1'b0);
    chk1("t3_rsp_valid", rsp_valid, 1'b1);
    chkw("t3_head_tag", 260'(rsp_tag), 260'(0));
    rsp_ready = 1'b1;
    tick();
    chk1("t3_ready_after_pop", req_ready, 1'b1);
    chki("t3_no_accept_on_pop", n_acc - acc0, int'(D));
    tick();
    chki("t3_fifth_accepted", n_acc - acc0, int'(D) + 1);
    req_tag = TW'(5);
    tick();
    chki("t3_sixth_accepted", n_acc - acc0, int'(D) + 2);
    req_valid = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    chk1("t3_idle", busy, 1'b0);
    chki("t3_sb_empty", sb_q.size(), 0);
    chk1("t3_ovf_end", ovf_err, 1'b0);

    // Simultaneous accept and pop with one credit left
    rsp_ready = 1'b0;
    acc0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < int'(D) - 1; i++) begin
      req_tag = TW'(8 + i);
      req_op0 = {8{$urandom}};
      req_op1 = {8{$urandom}};
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < int'(L) + 4; i++) tick();
    chk1("t4_credit1_ready", req_ready, 1'b1);
    req_valid = 1'b1; rsp_ready = 1'b1;
    req_tag = TW'(11); req_op0 = {8{$urandom}}; req_op1 = {8{$urandom}};
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk1("t4_ready_kept", req_ready, 1'b1);
    chk1("t4_busy", busy, 1'b1);
    chki("t4_accepted", n_acc - acc0, int'(D));
    chkw("t4_head_tag", 260'(rsp_tag), 260'(9));
    tick();
    chk1("t4_ready_idle", req_ready, 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) tick();
    chk1("t4_idle", busy, 1'b0);
    chki("t4_sb_empty", sb_q.size(), 0);

    // Reduction: (p-1)^2 mod p = 1
    m1 = (OPND_W'(1) << 255) - OPND_W'(20);
    req_valid = 1'b1; req_op0 = m1; req_op1 = m1; req_tag = TW'(7);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    chk1("t5_rsp_valid", rsp_valid, 1'b1);
    chkw("t5_rsp_data", 260'(rsp_data), 260'(1));
    chkw("t5_rsp_tag", 260'(rsp_tag), 260'(7));
    tick();

    // Reset with three ops in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_tag = TW'(i);
      req_op0 = {8{$urandom}};
      req_op1 = {8{$urandom}};
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk1("t6_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_rst");
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(L) + 6; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk1("t6_no_rsp_after_rst", seen, 1'b0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_req_ready", req_ready, 1'b1);
    chk1("t6_ovf", ovf_err, 1'b0);
    chki("t6_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
